// File: rtl/csi2_pkg.sv
// Shared definitions for the CSI-2 transmit path.
//   RAW10_*     : RAW10 packing geometry (pixels per word, bytes per word, pixel width)
//   px_slot_e   : slot index of the next pixel inside a RAW10 word
//   raw10_wc()  : long-packet word count (bytes) for a given pixel count
package csi2_pkg;

   localparam int RAW10_PX_PER_WORD = 4;
   localparam int RAW10_WORD_BYTES  = 5;
   localparam int RAW10_PX_W        = 10;

   typedef enum logic [1:0] {
      PX_0_S = 2'd0,
      PX_1_S = 2'd1,
      PX_2_S = 2'd2,
      PX_3_S = 2'd3
   } px_slot_e;

   // A partial last word still occupies a full 5-byte group on the wire.
   function automatic logic [15:0] raw10_wc(input logic [31:0] px_count);
      return 16'(((px_count + 32'(RAW10_PX_PER_WORD - 1)) / 32'(RAW10_PX_PER_WORD))
                 * 32'(RAW10_WORD_BYTES));
   endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// Minimal AXI4-Stream bundle.
//   DATA_W : tdata width in bits; tkeep/tstrb are DATA_W/8 bits
//   master : drives tdata/tkeep/tstrb/tvalid/tuser/tlast, samples tready
//   slave  : samples the payload, drives tready
interface axi4_stream_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0]   tdata;
   logic [DATA_W/8-1:0] tkeep;
   logic [DATA_W/8-1:0] tstrb;
   logic                tvalid;
   logic                tready;
   logic                tuser;
   logic                tlast;

   modport master (output tdata, tkeep, tstrb, tvalid, tuser, tlast, input tready);
   modport slave  (input tdata, tkeep, tstrb, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/csi2_line_stat.sv
// Per-line statistics for the CSI-2 packet header builder.
//   clk_i, rst_i : clock, async active-high reset
//   accept       : a pixel beat was accepted this cycle
//   last         : the accepted beat ends the line
//   line_px      : pixel count of the last completed line (saturated)
//   line_wc      : byte count of the last completed line
//   line_done    : one-cycle pulse after the line-ending beat
//   line_ovf     : sticky, a line ran past MAX_LINE_PX
module csi2_line_stat
   import csi2_pkg::*;
#(
   parameter  int MAX_LINE_PX = 4096,
   localparam int CNT_W       = $clog2(MAX_LINE_PX + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             accept,
   input  logic             last,
   output logic [CNT_W-1:0] line_px,
   output logic [15:0]      line_wc,
   output logic             line_done,
   output logic             line_ovf
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LINE_PX);

   logic [CNT_W-1:0] px_cnt;
   logic             at_max;
   logic [CNT_W-1:0] px_cnt_inc;

   assign at_max     = (px_cnt == CNT_MAX);
   assign px_cnt_inc = at_max ? CNT_MAX : px_cnt + CNT_W'(1);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         px_cnt    <= '0;
         line_px   <= '0;
         line_wc   <= '0;
         line_done <= 1'b0;
         line_ovf  <= 1'b0;
      end else begin
         line_done <= accept && last;
         if (accept) begin
            if (at_max) line_ovf <= 1'b1;
            if (last) begin
               line_px <= px_cnt_inc;
               line_wc <= raw10_wc(32'(px_cnt_inc));
               px_cnt  <= '0;
            end else begin
               px_cnt  <= px_cnt_inc;
            end
         end
      end
   end

endmodule

// File: rtl/csi2_px_packer.sv
// RAW10 pixel packer: four 10-bit pixels per 40-bit CSI-2 word.
//   clk_i, rst_i   : clock, async active-high reset
//   pkt_i          : 16-bit stream, pixel in tdata[9:0], tuser = frame start, tlast = end of line
//   pkt_o          : 40-bit packed RAW10 words, bytes 0-3 = MSBs, byte 4 = LSB pairs
//   frame_start_o  : pulse after a tuser beat is accepted
//   line_done_o    : pulse after a tlast beat is accepted
//   line_px_o      : pixel count of the last completed line
//   line_wc_o      : byte count of the last completed line
//   line_ovf_o     : sticky line-length overflow
//
// state  | meaning
// PX_0_S | next accepted pixel goes to slot 0 (word empty)
// PX_1_S | next accepted pixel goes to slot 1
// PX_2_S | next accepted pixel goes to slot 2
// PX_3_S | next accepted pixel completes the word
module csi2_px_packer
   import csi2_pkg::*;
#(
   parameter  int MAX_LINE_PX = 4096,
   localparam int CNT_W       = $clog2(MAX_LINE_PX + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   axi4_stream_if.slave       pkt_i,
   axi4_stream_if.master      pkt_o,
   output logic               frame_start_o,
   output logic               line_done_o,
   output logic [CNT_W-1:0]   line_px_o,
   output logic [15:0]        line_wc_o,
   output logic               line_ovf_o
);

   localparam int WORD_W = RAW10_WORD_BYTES * 8;

   px_slot_e                   state;
   logic [RAW10_PX_W-1:0]      acc0, acc1, acc2;
   logic                       word_tuser;
   logic [WORD_W-1:0]          out_data;
   logic                       out_valid, out_user, out_last;

   logic                       in_ready, accept, complete;
   logic [RAW10_PX_W-1:0]      pix;
   logic [RAW10_PX_PER_WORD-1:0][RAW10_PX_W-1:0] px_w;
   logic [WORD_W-1:0]          word;
   logic                       unused_in_bits;

   assign pix            = pkt_i.tdata[RAW10_PX_W-1:0];
   assign unused_in_bits = ^{pkt_i.tdata[15:RAW10_PX_W], pkt_i.tkeep, pkt_i.tstrb};

   // Ready depends only on the output register, never on input valid.
   assign in_ready    = !out_valid || pkt_o.tready;
   assign pkt_i.tready = in_ready;
   assign accept      = pkt_i.tvalid && in_ready;
   assign complete    = accept && ((state == PX_3_S) || pkt_i.tlast);

   // Slots above the current one are still cleared, so an early tlast pads with zeros.
   always_comb begin
      word        = '0;
      px_w        = {RAW10_PX_W'(0), acc2, acc1, acc0};
      px_w[state] = pix;
      for (int k = 0; k < RAW10_PX_PER_WORD; k++) begin
         word[8*k +: 8]      = px_w[k][RAW10_PX_W-1:2];
         word[32+2*k +: 2]   = px_w[k][1:0];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state         <= PX_0_S;
         acc0          <= '0;
         acc1          <= '0;
         acc2          <= '0;
         word_tuser    <= 1'b0;
         out_data      <= '0;
         out_valid     <= 1'b0;
         out_user      <= 1'b0;
         out_last      <= 1'b0;
         frame_start_o <= 1'b0;
      end else begin
         frame_start_o <= accept && pkt_i.tuser;

         if (complete) begin
            out_data  <= word;
            out_valid <= 1'b1;
            out_user  <= word_tuser | pkt_i.tuser;
            out_last  <= pkt_i.tlast;
         end else if (pkt_o.tready) begin
            out_valid <= 1'b0;
         end

         if (complete) begin
            state      <= PX_0_S;
            acc0       <= '0;
            acc1       <= '0;
            acc2       <= '0;
            word_tuser <= 1'b0;
         end else if (accept) begin
            state      <= px_slot_e'(state + 2'd1);
            word_tuser <= word_tuser | pkt_i.tuser;
            case (state)
               PX_0_S:  acc0 <= pix;
               PX_1_S:  acc1 <= pix;
               PX_2_S:  acc2 <= pix;
               default: ;
            endcase
         end
      end
   end

   assign pkt_o.tdata  = out_data;
   assign pkt_o.tvalid = out_valid;
   assign pkt_o.tuser  = out_user;
   assign pkt_o.tlast  = out_last;
   assign pkt_o.tkeep  = 5'h1F;
   assign pkt_o.tstrb  = 5'h1F;

   csi2_line_stat #(
      .MAX_LINE_PX (MAX_LINE_PX)
   ) u_line_stat (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .accept    (accept),
      .last      (pkt_i.tlast),
      .line_px   (line_px_o),
      .line_wc   (line_wc_o),
      .line_done (line_done_o),
      .line_ovf  (line_ovf_o)
   );

endmodule
